// File: rtl/sp_bram_bus_ram_pkg.sv
// Shared definitions for the block-RAM bus slave: size codes, FSM states
// and the byte-lane helpers used to right-justify bus data.
package sp_bram_bus_ram_pkg;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DONE = 2'd2
  } state_e;

  // Moves data between the right-justified bus view and the byte lanes of a
  // memory word; to_upper=1 places bus data onto lanes, 0 brings lanes down.
  function automatic logic [31:0] lane_shift(input logic [31:0] data,
                                             input logic [1:0]  lane,
                                             input logic        to_upper);
    logic [31:0] res;
    if (to_upper) begin
      res = data << {lane, 3'b000};
    end else begin
      res = data >> {lane, 3'b000};
    end
    return res;
  endfunction

  // Keeps only the bits that belong to the access size, zero-extending reads.
  function automatic logic [31:0] size_mask(input logic [3:0] be);
    logic [31:0] m;
    case (be)
      BE_BYTE: m = 32'h0000_00FF;
      BE_HALF: m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sp_bram_bus_ram_if.sv
// Simple enable/ready system bus between an interconnect master and a slave.
interface sp_bram_bus_ram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic [3:0]            be;
  logic                  ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  irq;
  logic                  bus_err;

  modport master (
    output enable, wr_en, addr, i_data, be,
    input  ready, o_data, irq, bus_err
  );

  modport slave (
    input  enable, wr_en, addr, i_data, be,
    output ready, o_data, irq, bus_err
  );
endinterface

// File: rtl/sp_bram_array.sv
// Single-port word RAM with per-byte write enables and a registered read
// port, written in the shape synthesis maps onto block RAM. Contents are
// intentionally not reset.
module sp_bram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Byte-lane writes and read-before-write registered output
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sp_bram_bus_ram.sv
// Byte-addressed block-RAM slave: checks size/alignment, maps right-justified
// bus data onto byte lanes, and sequences reads through the registered RAM.
module sp_bram_bus_ram
  import sp_bram_bus_ram_pkg::*;
#(
  parameter int WIDTH      = 8192,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sp_bram_bus_ram_if.slave     bus
);

  localparam int DEPTH = WIDTH / 32;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BYTES = ADDR_WIDTH'(WIDTH / 8);

  // Latched request and registered outputs
  state_e          state_r,    state_s;
  logic [3:0]      be_r,       be_s;
  logic [1:0]      ofs_r,      ofs_s;
  logic [AW-1:0]   idx_r,      idx_s;
  logic [31:0]     wdata_r,    wdata_s;
  logic            commit_r,   commit_s;
  logic            rd_valid_r, rd_valid_s;
  logic            ready_r,    ready_s;
  logic            bus_err_r,  bus_err_s;
  logic [31:0]     o_data_r,   o_data_s;

  logic            req_err_s;
  logic            mem_en_s;
  logic [3:0]      mem_we_s;
  logic [31:0]     mem_rdata_s;

  // Request legality: size code, natural alignment and address range
  always_comb begin
    req_err_s = 1'b0;
    case (bus.be)
      BE_BYTE: req_err_s = 1'b0;
      BE_HALF: req_err_s = bus.addr[0];
      BE_WORD: req_err_s = (bus.addr[1:0] != 2'b00);
      default: req_err_s = 1'b1;
    endcase
    if (bus.addr >= BYTES) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = req_err_s;
    end
  end

  // Next-state and next-output decisions of the transaction FSM
  always_comb begin
    state_s    = state_r;
    be_s       = be_r;
    ofs_s      = ofs_r;
    idx_s      = idx_r;
    wdata_s    = wdata_r;
    commit_s   = 1'b0;
    rd_valid_s = 1'b0;
    ready_s    = ready_r;
    bus_err_s  = bus_err_r;
    o_data_s   = o_data_r;
    case (state_r)
      IDLE: begin
        if (bus.enable) begin
          be_s    = bus.be;
          ofs_s   = bus.addr[1:0];
          idx_s   = bus.addr[AW+1:2];
          wdata_s = lane_shift(bus.i_data, bus.addr[1:0], 1'b1);
          if (req_err_s) begin
            state_s   = DONE;
            ready_s   = 1'b1;
            bus_err_s = 1'b1;
          end else if (bus.wr_en) begin
            // The write commits on the next edge; ready follows it.
            state_s  = DONE;
            commit_s = 1'b1;
          end else begin
            state_s = RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (rd_valid_r) begin
          o_data_s = lane_shift(mem_rdata_s, ofs_r, 1'b0) & size_mask(be_r);
          ready_s  = 1'b1;
          state_s  = DONE;
        end else begin
          rd_valid_s = 1'b1;
        end
      end
      DONE: begin
        if (commit_r) begin
          ready_s = 1'b1;
        end else if (!bus.enable) begin
          state_s   = IDLE;
          ready_s   = 1'b0;
          bus_err_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s   = IDLE;
        ready_s   = 1'b0;
        bus_err_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any open transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      be_r       <= 4'b0000;
      ofs_r      <= 2'b00;
      idx_r      <= '0;
      wdata_r    <= 32'h0000_0000;
      commit_r   <= 1'b0;
      rd_valid_r <= 1'b0;
      ready_r    <= 1'b0;
      bus_err_r  <= 1'b0;
      o_data_r   <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      be_r       <= be_s;
      ofs_r      <= ofs_s;
      idx_r      <= idx_s;
      wdata_r    <= wdata_s;
      commit_r   <= commit_s;
      rd_valid_r <= rd_valid_s;
      ready_r    <= ready_s;
      bus_err_r  <= bus_err_s;
      o_data_r   <= o_data_s;
    end
  end

  // RAM port control: enabled while reading or committing a write
  always_comb begin
    mem_en_s = (state_r == RD) || commit_r;
    if (commit_r) begin
      mem_we_s = be_r << ofs_r;
    end else begin
      mem_we_s = 4'b0000;
    end
  end

  sp_bram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (mem_en_s),
    .we    (mem_we_s),
    .addr  (idx_r),
    .wdata (wdata_r),
    .rdata (mem_rdata_s)
  );

  assign bus.ready   = ready_r;
  assign bus.bus_err = bus_err_r;
  assign bus.o_data  = o_data_r;
  assign bus.irq     = 1'b0;

endmodule

// File: tb/tb_sp_bram_bus_ram.sv
// Directed bench for the block-RAM bus slave: error handling, lane mapping,
// full byte sweep, latency, early enable drop and mid-read reset.
module tb_sp_bram_bus_ram;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  sp_bram_bus_ram_if bus_if ();

  sp_bram_bus_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus transaction; returns captured data, error flag and edges to ready.
  task automatic bus_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output logic [31:0] rd,
                         output logic err, output int lat);
    @(negedge clk);
    bus_if.enable = 1'b1;
    bus_if.wr_en  = wr;
    bus_if.addr   = a;
    bus_if.i_data = d;
    bus_if.be     = b;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus_if.ready) break;
    end
    if (!bus_if.ready) check_eq("timeout", {31'd0, bus_if.ready}, 32'd1);
    rd  = bus_if.o_data;
    err = bus_if.bus_err;
    @(negedge clk);
    bus_if.enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rdy_fall", {30'd0, bus_if.ready, bus_if.bus_err}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  logic [31:0] a;
  logic [31:0] exp_b;
  logic        seen;
  logic [31:0] od;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.enable = 1'b0;
    bus_if.wr_en  = 1'b0;
    bus_if.addr   = 32'd0;
    bus_if.i_data = 32'd0;
    bus_if.be     = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, bus_if.ready}, 32'd0);
    check_eq("rst_err", {31'd0, bus_if.bus_err}, 32'd0);
    check_eq("rst_odata", bus_if.o_data, 32'd0);
    check_eq("rst_irq", {31'd0, bus_if.irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known word, then misaligned writes must leave it alone
    bus_txn(1'b1, 32'h0, 32'hDEAD_BEEF, 4'b1111, rd, err, lat);
    check_eq("wr_err", {31'd0, err}, 32'd0);
    check_eq("wr_lat", lat, 32'd2);
    for (int i = 1; i < 4; i++) begin
      bus_txn(1'b1, i, 32'h1234_5678, 4'b1111, rd, err, lat);
      check_eq("mis_word_err", {31'd0, err}, 32'd1);
      check_eq("err_lat", lat, 32'd1);
      check_eq("err_odata", rd, 32'd0);
    end
    bus_txn(1'b1, 32'h1, 32'h0000_9999, 4'b0011, rd, err, lat);
    check_eq("mis_half_err", {31'd0, err}, 32'd1);
    bus_txn(1'b0, 32'h0, 32'h0, 4'b1111, rd, err, lat);
    check_eq("after_err_clr", {31'd0, err}, 32'd0);
    check_eq("mem_unchanged", rd, 32'hDEAD_BEEF);
    check_eq("rd_lat", lat, 32'd3);

    // Word write, then word/half/byte reads
    bus_txn(1'b1, 32'h10, 32'h1122_3344, 4'b1111, rd, err, lat);
    bus_txn(1'b0, 32'h10, 32'h0, 4'b1111, rd, err, lat);
    check_eq("rd_w10", rd, 32'h1122_3344);
    bus_txn(1'b0, 32'h10, 32'h0, 4'b0011, rd, err, lat);
    check_eq("rd_h10", rd, 32'h0000_3344);
    bus_txn(1'b0, 32'h12, 32'h0, 4'b0011, rd, err, lat);
    check_eq("rd_h12", rd, 32'h0000_1122);
    bus_txn(1'b0, 32'h10, 32'h0, 4'b0001, rd, err, lat);
    check_eq("rd_b10", rd, 32'h0000_0044);
    bus_txn(1'b0, 32'h11, 32'h0, 4'b0001, rd, err, lat);
    check_eq("rd_b11", rd, 32'h0000_0033);
    bus_txn(1'b0, 32'h12, 32'h0, 4'b0001, rd, err, lat);
    check_eq("rd_b12", rd, 32'h0000_0022);
    bus_txn(1'b0, 32'h13, 32'h0, 4'b0001, rd, err, lat);
    check_eq("rd_b13", rd, 32'h0000_0011);

    // Half write with junk upper bits only touches the low two lanes
    bus_txn(1'b1, 32'h20, 32'h0, 4'b1111, rd, err, lat);
    bus_txn(1'b1, 32'h20, 32'hFFFF_5566, 4'b0011, rd, err, lat);
    bus_txn(1'b0, 32'h20, 32'h0, 4'b1111, rd, err, lat);
    check_eq("rd_w20", rd, 32'h0000_5566);
    bus_txn(1'b1, 32'h30, 32'h0000_0077, 4'b0001, rd, err, lat);
    bus_txn(1'b1, 32'h31, 32'h0000_0088, 4'b0001, rd, err, lat);
    bus_txn(1'b1, 32'h32, 32'h0000_0099, 4'b0001, rd, err, lat);
    bus_txn(1'b1, 32'h33, 32'hFFFF_FFAA, 4'b0001, rd, err, lat);
    bus_txn(1'b0, 32'h30, 32'h0, 4'b1111, rd, err, lat);
    check_eq("rd_w30", rd, 32'hAA99_8877);

    // Out-of-range and illegal size code
    bus_txn(1'b0, 32'h400, 32'h0, 4'b1111, rd, err, lat);
    check_eq("oor_err", {31'd0, err}, 32'd1);
    check_eq("oor_lat", lat, 32'd1);
    bus_txn(1'b0, 32'h0, 32'h0, 4'b0110, rd, err, lat);
    check_eq("be_err", {31'd0, err}, 32'd1);

    // Full byte sweep then random byte reads
    for (int x = 0; x < 1024; x++) begin
      exp_b = 32'(255 - x) & 32'hFF;
      bus_txn(1'b1, 32'(x), exp_b, 4'b0001, rd, err, lat);
    end
    for (int k = 0; k < 1024; k++) begin
      a = 32'($urandom_range(0, 1023));
      exp_b = (32'd255 - a) & 32'hFF;
      bus_txn(1'b0, a, 32'h0, 4'b0001, rd, err, lat);
      check_eq("sweep_rd", rd, exp_b);
    end
    bus_txn(1'b0, 32'h3FC, 32'h0, 4'b1111, rd, err, lat);
    check_eq("rd_last_word", rd, 32'h0001_0203);
    check_eq("last_word_err", {31'd0, err}, 32'd0);

    // Enable dropped right after acceptance: request completes, ready pulses
    @(negedge clk);
    bus_if.enable = 1'b1;
    bus_if.wr_en  = 1'b0;
    bus_if.addr   = 32'h4;
    bus_if.be     = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    bus_if.enable = 1'b0;
    seen = 1'b0;
    od   = 32'd0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.ready) begin
        seen = 1'b1;
        od   = bus_if.o_data;
      end
    end
    check_eq("early_seen", {31'd0, seen}, 32'd1);
    check_eq("early_data", od, 32'hF8F9_FAFB);
    @(posedge clk);
    #1;
    check_eq("early_pulse", {31'd0, bus_if.ready}, 32'd0);

    // Reset during a read clears outputs at once; next read is normal
    bus_txn(1'b0, 32'h0, 32'h0, 4'b1111, rd, err, lat);
    check_eq("pre_rst_rd", rd, 32'hFCFD_FEFF);
    @(negedge clk);
    bus_if.enable = 1'b1;
    bus_if.wr_en  = 1'b0;
    bus_if.addr   = 32'h10;
    bus_if.be     = 4'b1111;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", {31'd0, bus_if.ready}, 32'd0);
    check_eq("midrst_err", {31'd0, bus_if.bus_err}, 32'd0);
    check_eq("midrst_odata", bus_if.o_data, 32'd0);
    bus_if.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_txn(1'b0, 32'h10, 32'h0, 4'b1111, rd, err, lat);
    check_eq("post_rst_rd", rd, 32'hECED_EEEF);
    check_eq("post_rst_lat", lat, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
